score_display: RTL and testbench
================================

# score_display

Downstream consumer of the game's 16-bit `score_out`. It converts the binary score to four BCD digits with a sequential shift-and-add-3 engine and time-multiplexes them onto the board's 4-digit active-low seven-segment display. Leading zeros are blanked. The block runs on the same clock as the graphics stage and needs no handshake from it: it re-converts whenever the score value changes.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clocks per digit slot. 1 kHz per digit at 100 MHz. Legal range is ≥2.
- `DIGITS`, default 4: number of display digits. Fixed at 4 in this revision.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-low
- `score_in`  in  16  binary score from the graphics stage
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low
- `dp`  out  1  decimal point, active-low; always 1 (off)
- `an`  out  4  digit anodes, active-low; `an[0]` is the ones digit
- `bcd_out`  out  16  committed BCD `{thousands,hundreds,tens,ones}`
- `busy`  out  1  conversion in progress

## Operation
- **Clamp:** any `score_in` > 9999 is converted as 9999.
- **Converter FSM:** states IDLE, SHIFT, DONE.
  - IDLE: if `!cap_valid` or `score_in != last_score`, then
    - load `last_score <= score_in`,
    - load the 14-bit shift register with the clamped value,
    - clear the BCD scratch and `cnt`,
    - set `cap_valid`, go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift `{scratch, shreg}` left by 1 and increment `cnt`. After the 14th shift, go to DONE.
  - DONE: `bcd_out <= scratch`, go to IDLE.
- **Mid-conversion changes:** a change of `score_in` during SHIFT/DONE is ignored until IDLE. IDLE then sees the mismatch and restarts, so the final value always converges.
- **Scan:** `refresh_cnt` counts 0..`REFRESH_DIV`-1. On wrap, `digit_idx` advances 0→1→2→3→0 (2 bits, natural wrap).
- **Blanking:** digit k (k = 1..3) is blanked if it and all higher digits are zero. Digit 0 is never blanked.
- **Segment encoding:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank and any nibble >9 give 1111111.

## Timing
- **Reset values** (next edge with `reset`=0):
  - Converter: state IDLE, `cap_valid` 0, `last_score` 0, `bcd_out` 0, `busy` 0.
  - Scan: `refresh_cnt` 0, `digit_idx` 0.
  - Outputs: `an` 1111, `seg` 1111111, `dp` 1.
- **Conversion latency:** change of `score_in` to new `bcd_out` is 16 edges (1 capture + 14 shift + 1 commit), measured from IDLE.
- **Post-reset:** the first conversion starts on the first edge after `reset` rises, because `cap_valid`=0.
- **`busy`:** high from the capture edge through the DONE cycle, exactly 15 cycles, then low. Back-to-back changes give back-to-back conversions with one IDLE cycle between them.
- **`an`/`seg` registration:** both are registered from `digit_idx` and `bcd_out`, 1 cycle behind. `an` has exactly one bit low at any time after the first post-reset cycle.
- **Reset mid-conversion:** reset aborts the conversion. `bcd_out` returns to 0 and a fresh conversion of the current `score_in` follows.

## Structure
- Shared package `ddr_pkg`:
  - `SEG_DIGIT[0:9]` encodings and `SEG_BLANK`,
  - `BCD_DIGITS` = 4,
  - `SCORE_MAX` = 9999,
  - converter state enum.
- Sub-module `bin2bcd_seq`:
  - contains the converter FSM,
  - ports: `clk`, `reset`, `bin`[15:0], `bcd`[15:0], `busy`.
- The top level holds the scan counter, blanking and segment decode.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- **Reset:** hold reset 3 cycles with `score_in`=0 → `an`=1111, `seg`=1111111, `bcd_out`=0. After release: `busy`=1 for 15 cycles; `an`=1110 with `seg`=1000000; `an`=1101/1011/0111 show 1111111 (blanked).
- **Basic conversion:** `score_in`=1234 → `bcd_out`=0x1234 exactly 16 edges after the change. Scan shows 4, 3, 2, 1 on `an`=1110, 1101, 1011, 0111, each held 4 cycles.
- **Clamp:** `score_in`=65535 → `bcd_out`=0x9999. With `score_in`=10000 → 0x9999.
- **Mid-conversion change:** change 7→42 on the 5th SHIFT cycle → first `bcd_out`=0x0007, then 0x0042 exactly 16 edges after the first commit. Display shows "42" with the upper two digits blanked.
- **Interior zeros:** `score_in`=1005 → digits 1,0,0,5 all lit; the interior zeros show 1000000.
- **Reset mid-conversion:** assert reset on the 8th SHIFT cycle of 9999 → `bcd_out`=0. After release `busy` goes high, and `bcd_out`=0x9999 16 edges after release.

Source files
------------

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared constants, segment table and converter state for the score display
package ddr_pkg;

  localparam int BCD_DIGITS = 4;
  localparam logic [15:0] SCORE_MAX = 16'd9999;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib, input logic blank);
    if (blank || nib > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_DIGIT[nib];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 converter, re-runs whenever bin changes
module bin2bcd_seq
  import ddr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bin,
  output logic [15:0] bcd,
  output logic        busy
);

  conv_state_e state, state_next;

  logic        cap_valid;
  logic [15:0] last_score;
  logic [13:0] shreg;
  logic [15:0] scratch;
  logic [3:0]  cnt;
  logic [13:0] clamped;
  logic [15:0] adjusted;
  logic [29:0] shifted;
  logic        start;

  assign clamped = (bin > SCORE_MAX) ? SCORE_MAX[13:0] : bin[13:0];
  assign start   = !cap_valid || (bin != last_score);

  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Thousands nibble never exceeds 9, so the bit shifted out of the top is always zero.
  assign shifted = {adjusted, shreg} << 1;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      CONV_IDLE: begin
        if (start) begin
          state_next = CONV_SHIFT;
        end
      end
      CONV_SHIFT: begin
        busy = 1'b1;
        if (cnt == 4'd13) begin
          state_next = CONV_DONE;
        end
      end
      CONV_DONE: begin
        busy       = 1'b1;
        state_next = CONV_IDLE;
      end
      default: state_next = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= CONV_IDLE;
      cap_valid  <= 1'b0;
      last_score <= 16'd0;
      shreg      <= 14'd0;
      scratch    <= 16'd0;
      cnt        <= 4'd0;
      bcd        <= 16'd0;
    end else begin
      state <= state_next;
      case (state)
        CONV_IDLE: begin
          if (start) begin
            last_score <= bin;
            shreg      <= clamped;
            scratch    <= 16'd0;
            cnt        <= 4'd0;
            cap_valid  <= 1'b1;
          end
        end
        CONV_SHIFT: begin
          scratch <= shifted[29:14];
          shreg   <= shifted[13:0];
          cnt     <= cnt + 4'd1;
        end
        CONV_DONE: begin
          bcd <= scratch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/score_display.sv
// rtl/score_display.sv - score to BCD conversion and multiplexed active-low seven-segment drive
module score_display
  import ddr_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIGITS      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       score_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic [15:0]       bcd_out,
  output logic              busy
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    lit;
  logic [3:0]    nibble;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (score_in),
    .bcd   (bcd_out),
    .busy  (busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // lit[k]: digit k or some higher digit is non-zero; the ones digit always shows.
  always_comb begin
    lit[3] = |bcd_out[15:12];
    lit[2] = lit[3] | (|bcd_out[11:8]);
    lit[1] = lit[2] | (|bcd_out[7:4]);
    lit[0] = 1'b1;
  end

  assign nibble = bcd_out[{digit_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= seg_encode(nibble, !lit[digit_idx]);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed bench with a cycle-level reference model of the score display
module tb_score_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] score_in = 16'd0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] bcd_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit         m_valid = 1'b0;
  bit         m_live = 1'b0;
  int         m_last = 0;
  int         m_bcd = 0;
  int         m_left = 0;
  int         m_pend = 0;
  int         m_k = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(RD), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .score_in (score_in),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .bcd_out  (bcd_out),
    .busy     (busy)
  );

  function automatic logic [6:0] seg_ref(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int to_bcd(int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return (c / 1000) * 4096 + ((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + (c % 10);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int d;
    if (!reset) begin
      m_valid = 1'b0;
      m_last  = 0;
      m_bcd   = 0;
      m_left  = 0;
      m_k     = 0;
      m_an    = 4'hF;
      m_seg   = 7'h7F;
    end else begin
      d     = (m_k / RD) % 4;
      m_an  = 4'hF ^ (4'b0001 << d);
      m_seg = (d > 0 && (m_bcd >> (4 * d)) == 0) ? 7'h7F : seg_ref((m_bcd >> (4 * d)) & 15);
      m_k++;
      if (m_left == 0) begin
        if (!m_valid || int'(score_in) != m_last) begin
          m_last  = int'(score_in);
          m_valid = 1'b1;
          m_left  = 15;
          m_pend  = to_bcd(int'(score_in));
        end
      end else begin
        m_left--;
        if (m_left == 0) m_bcd = m_pend;
      end
    end
    m_live = 1'b1;
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic wait_an(logic [3:0] target, logic [6:0] seg_exp, string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1'b1;
        check(name, seg, seg_exp);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: anode %b never selected within 40 cycles", name, target);
    end
  endtask

  task automatic conv(int v, int exp, string name);
    score_in = 16'(v);
    edges(16);
    look();
    check(name, bcd_out, exp);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        model_edge();
      end
      forever begin
        @(negedge clk);
        if (m_live) begin
          check("model bcd_out", bcd_out, m_bcd);
          check("model busy", busy, m_left != 0);
          check("model an", an, m_an);
          check("model seg", seg, m_seg);
          check("model dp", dp, 1);
        end
      end
    join_none

    // Reset held three cycles
    edges(3);
    look();
    check("reset an", an, 4'b1111);
    check("reset seg", seg, 7'b1111111);
    check("reset bcd_out", bcd_out, 16'h0000);
    check("reset busy", busy, 1'b0);
    reset = 1'b1;

    // Post-reset conversion of 0
    edges(1);
    look();
    check("post-reset busy", busy, 1'b1);
    check("post-reset an", an, 4'b1110);
    check("post-reset seg", seg, 7'b1000000);
    edges(14);
    look();
    check("busy 15th cycle", busy, 1'b1);
    edges(1);
    look();
    check("busy drops", busy, 1'b0);
    check("zero an", an, 4'b0111);
    check("zero blank", seg, 7'b1111111);

    // Basic conversion and latency
    score_in = 16'd1234;
    edges(15);
    look();
    check("1234 at 15 edges", bcd_out, 16'h0000);
    edges(1);
    look();
    check("1234 at 16 edges", bcd_out, 16'h1234);
    wait_an(4'b1110, 7'b0011001, "1234 ones");
    wait_an(4'b1101, 7'b0110000, "1234 tens");
    wait_an(4'b1011, 7'b0100100, "1234 hundreds");
    wait_an(4'b0111, 7'b1111001, "1234 thousands");

    // Clamp
    conv(65535, 16'h9999, "clamp 65535");
    conv(10000, 16'h9999, "clamp 10000");
    conv(9999, 16'h9999, "max 9999");

    // Mid-conversion change 7 -> 42
    score_in = 16'd7;
    edges(5);
    score_in = 16'd42;
    edges(11);
    look();
    check("first commit 7", bcd_out, 16'h0007);
    edges(15);
    look();
    check("42 not yet", bcd_out, 16'h0007);
    edges(1);
    look();
    check("42 commit", bcd_out, 16'h0042);
    wait_an(4'b1110, 7'b0100100, "42 ones");
    wait_an(4'b1101, 7'b0011001, "42 tens");
    wait_an(4'b1011, 7'b1111111, "42 hundreds blank");
    wait_an(4'b0111, 7'b1111111, "42 thousands blank");

    // Interior zeros
    conv(1005, 16'h1005, "1005 commit");
    wait_an(4'b0111, 7'b1111001, "1005 thousands");
    wait_an(4'b1011, 7'b1000000, "1005 hundreds");
    wait_an(4'b1101, 7'b1000000, "1005 tens");
    wait_an(4'b1110, 7'b0010010, "1005 ones");

    // Reset on the 8th SHIFT cycle of 9999
    conv(0, 16'h0000, "back to 0");
    score_in = 16'd9999;
    edges(8);
    reset = 1'b0;
    edges(1);
    look();
    check("abort bcd_out", bcd_out, 16'h0000);
    check("abort busy", busy, 1'b0);
    check("abort an", an, 4'b1111);
    reset = 1'b1;
    edges(1);
    look();
    check("restart busy", busy, 1'b1);
    edges(14);
    look();
    check("restart at 15", bcd_out, 16'h0000);
    edges(1);
    look();
    check("restart at 16", bcd_out, 16'h9999);
    edges(4);

    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
